// File: rtl/acc_cpu_core_pkg.sv
// Shared definitions for the accumulator CPU core: opcode encodings and FSM states.
package acc_cpu_core_pkg;

   localparam int unsigned OPC_W = 4;

   localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
   localparam logic [OPC_W-1:0] OP_LDI  = 4'h1;
   localparam logic [OPC_W-1:0] OP_ADD  = 4'h2;
   localparam logic [OPC_W-1:0] OP_SUB  = 4'h3;
   localparam logic [OPC_W-1:0] OP_AND  = 4'h4;
   localparam logic [OPC_W-1:0] OP_OR   = 4'h5;
   localparam logic [OPC_W-1:0] OP_XOR  = 4'h6;
   localparam logic [OPC_W-1:0] OP_JMP  = 4'h8;
   localparam logic [OPC_W-1:0] OP_JZ   = 4'h9;
   localparam logic [OPC_W-1:0] OP_JC   = 4'hA;
   localparam logic [OPC_W-1:0] OP_JNZ  = 4'hB;
   localparam logic [OPC_W-1:0] OP_JR   = 4'hC;
   localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

   typedef enum logic [1:0] {
      FETCH_OP  = 2'd0,
      FETCH_ARG = 2'd1,
      EXEC      = 2'd2,
      HALTED    = 2'd3
   } state_t;

endpackage

// File: rtl/acc_cpu_core_if.sv
// Instruction-memory fetch port: req/addr from the core, ack/rdata from memory.
//   req   : fetch request, held with addr stable until ack
//   addr  : fetch address
//   ack   : rdata valid this cycle
//   rdata : fetched word
interface acc_cpu_core_if #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned ADDR_W = 4
);
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (output req, addr, input ack, rdata);
   modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/acc_cpu_core_alu.sv
// Combinational ALU for the accumulator core.
//   a, b   : accumulator and operand
//   op     : opcode (non-ALU codes pass a through)
//   result : new accumulator value
//   carry  : ADD carry-out, SUB no-borrow, 0 otherwise
//   zero   : result == 0
module alu_n
   import acc_cpu_core_pkg::*;
#(
   parameter int unsigned DATA_W = 4
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [OPC_W-1:0]  op,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              zero
);

   always_comb begin
      result = a;
      carry  = 1'b0;
      case (op)
         OP_LDI: result = b;
         OP_ADD: {carry, result} = (DATA_W+1)'(a) + (DATA_W+1)'(b);
         OP_SUB: begin
            result = a - b;
            carry  = (a >= b);
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         default: result = a;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: fetches opcode/operand word pairs, executes ALU, load,
// branch and halt instructions on a DATA_W accumulator with Z/C flags.
//   clk, reset : clock, asynchronous active-low reset
//   imem       : instruction fetch port (master side)
//   resume     : leave HALTED
//   acc        : accumulator
//   flag_z     : zero flag
//   flag_c     : carry / no-borrow flag
//   pc         : address of the next instruction to fetch
//   halted     : high while halted
//   retire     : high for the EXEC cycle of each instruction
module acc_cpu_core
   import acc_cpu_core_pkg::*;
#(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned ADDR_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   acc_cpu_core_if.master       imem,
   input  logic                 resume,
   output logic [DATA_W-1:0]    acc,
   output logic                 flag_z,
   output logic                 flag_c,
   output logic [ADDR_W-1:0]    pc,
   output logic                 halted,
   output logic                 retire
);

   state_t              state;
   logic [OPC_W-1:0]    opcode;
   logic [DATA_W-1:0]   operand;

   logic [DATA_W-1:0]   alu_result;
   logic                alu_carry;
   logic                alu_zero;

   logic [ADDR_W-1:0]   op_addr;
   logic [ADDR_W-1:0]   pc_seq;
   logic [ADDR_W-1:0]   pc_exec;

   alu_n #(.DATA_W(DATA_W)) u_alu (
      .a      (acc),
      .b      (operand),
      .op     (opcode),
      .result (alu_result),
      .carry  (alu_carry),
      .zero   (alu_zero)
   );

   // pc holds pc_instr until EXEC, so all targets are relative to it.
   assign op_addr = operand[ADDR_W-1:0];
   assign pc_seq  = pc + ADDR_W'(2);

   // Next pc at the end of EXEC.
   always_comb begin
      pc_exec = pc_seq;
      case (opcode)
         OP_JMP: pc_exec = op_addr;
         OP_JZ:  if (flag_z)  pc_exec = op_addr;
         OP_JC:  if (flag_c)  pc_exec = op_addr;
         OP_JNZ: if (!flag_z) pc_exec = op_addr;
         OP_JR:  pc_exec = pc + op_addr;
         default: pc_exec = pc_seq;
      endcase
   end

   // Control FSM with registered fetch port and architectural state.
   // req is 0 in reset, so the first FETCH_OP cycle only raises req; any ack
   // seen without an outstanding request is ignored.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= FETCH_OP;
         opcode    <= OP_NOP;
         operand   <= '0;
         acc       <= '0;
         flag_z    <= 1'b0;
         flag_c    <= 1'b0;
         pc        <= '0;
         halted    <= 1'b0;
         retire    <= 1'b0;
         imem.req  <= 1'b0;
         imem.addr <= '0;
      end else begin
         retire <= 1'b0;
         case (state)
            FETCH_OP: begin
               if (!imem.req) begin
                  imem.req  <= 1'b1;
                  imem.addr <= pc;
               end else if (imem.ack) begin
                  opcode    <= imem.rdata[OPC_W-1:0];
                  imem.addr <= pc + ADDR_W'(1);
                  state     <= FETCH_ARG;
               end
            end
            FETCH_ARG: begin
               if (imem.ack) begin
                  operand  <= imem.rdata;
                  imem.req <= 1'b0;
                  retire   <= 1'b1;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               case (opcode)
                  OP_LDI: begin
                     acc    <= alu_result;
                     flag_z <= alu_zero;
                  end
                  OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                     acc    <= alu_result;
                     flag_z <= alu_zero;
                     flag_c <= alu_carry;
                  end
                  default: ;
               endcase
               pc        <= pc_exec;
               imem.addr <= pc_exec;
               if (opcode == OP_HALT) begin
                  halted <= 1'b1;
                  state  <= HALTED;
               end else begin
                  imem.req <= 1'b1;
                  state    <= FETCH_OP;
               end
            end
            HALTED: begin
               if (resume) begin
                  halted   <= 1'b0;
                  imem.req <= 1'b1;
                  state    <= FETCH_OP;
               end
            end
            default: state <= FETCH_OP;
         endcase
      end
   end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core with a small program memory model.
module tb_acc_cpu_core;
   import acc_cpu_core_pkg::*;

   localparam int unsigned DATA_W = 4;
   localparam int unsigned ADDR_W = 4;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              resume = 1'b0;
   logic [DATA_W-1:0] acc;
   logic              flag_z, flag_c, halted, retire;
   logic [ADDR_W-1:0] pc;

   acc_cpu_core_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) imem ();

   acc_cpu_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk    (clk),
      .reset  (reset),
      .imem   (imem),
      .resume (resume),
      .acc    (acc),
      .flag_z (flag_z),
      .flag_c (flag_c),
      .pc     (pc),
      .halted (halted),
      .retire (retire)
   );

   always #5 clk = ~clk;

   // Program memory: acks after wait_n request cycles; late_ack forces ack.
   logic [3:0] mem [16];
   int         wait_n = 0;
   int         wcnt;
   logic       late_ack = 1'b0;

   assign imem.ack   = (imem.req && (wcnt >= wait_n)) || late_ack;
   assign imem.rdata = mem[imem.addr];

   always @(posedge clk or negedge reset) begin
      if (!reset) wcnt <= 0;
      else if (imem.req && !imem.ack) wcnt <= wcnt + 1;
      else wcnt <= 0;
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Image is 16 nibbles, address 0 in the most significant nibble.
   task automatic load(input logic [63:0] img);
      for (int i = 0; i < 16; i++) mem[i] = img[63-4*i -: 4];
   endtask

   task automatic do_reset(input logic [63:0] img);
      @(negedge clk);
      reset = 1'b0;
      load(img);
      #1;
      check("rst_req", 32'(imem.req), 32'd0);
      check("rst_acc", 32'(acc), 32'd0);
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_flags", 32'({flag_z, flag_c, halted, retire}), 32'd0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   int              cycles, nret, first_ret, nlog;
   logic [ADDR_W-1:0] pc_log  [8];
   logic [DATA_W-1:0] acc_log [8];
   logic              z_log   [8];
   logic              c_log   [8];

   // Steps until halted; checks request stability and logs state after each retire.
   task automatic run(input int budget);
      logic              started = 1'b0;
      logic              prev_ret = 1'b0;
      logic              p_req = 1'b0;
      logic              p_ack = 1'b0;
      logic [ADDR_W-1:0] p_addr = '0;
      cycles = 0; nret = 0; first_ret = 0; nlog = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (p_req && !p_ack) begin
            check("hold_req", 32'(imem.req), 32'd1);
            check("hold_addr", 32'(imem.addr), 32'(p_addr));
         end
         p_req = imem.req; p_ack = imem.ack; p_addr = imem.addr;
         if (prev_ret && nlog < 8) begin
            pc_log[nlog] = pc; acc_log[nlog] = acc;
            z_log[nlog] = flag_z; c_log[nlog] = flag_c;
            nlog++;
         end
         prev_ret = retire;
         if (halted) break;
         if (started || imem.req) begin
            started = 1'b1;
            cycles++;
         end
         if (retire) begin
            nret++;
            if (first_ret == 0) first_ret = cycles;
         end
      end
      check("halt_reached", 32'(halted), 32'd1);
   endtask

   initial begin
      // 1: LDI 1; ADD 1; HALT
      do_reset(64'h1121F00000000000);
      run(100);
      check("t1_acc", 32'(acc), 32'h2);
      check("t1_zc", 32'({flag_z, flag_c}), 32'd0);
      check("t1_retires", 32'(nret), 32'd3);
      check("t1_pc", 32'(pc), 32'h6);
      check("t1_cycles", 32'(cycles), 32'd9);
      check("t1_first_ret", 32'(first_ret), 32'd3);

      // 2: LDI F; ADD 1; JZ 8; (8) HALT
      do_reset(64'h1F219800F0000000);
      run(100);
      check("t2_add_acc", 32'(acc_log[1]), 32'h0);
      check("t2_add_zc", 32'({z_log[1], c_log[1]}), 32'b11);
      check("t2_jz_pc", 32'(pc_log[2]), 32'h8);
      check("t2_acc", 32'(acc), 32'h0);
      check("t2_zc", 32'({flag_z, flag_c}), 32'b11);
      check("t2_pc", 32'(pc), 32'hA);

      // 3: LDI 3; SUB 5; SUB E; HALT
      do_reset(64'h13353EF000000000);
      run(100);
      check("t3_sub5_acc", 32'(acc_log[1]), 32'hE);
      check("t3_sub5_zc", 32'({z_log[1], c_log[1]}), 32'b00);
      check("t3_acc", 32'(acc), 32'h0);
      check("t3_zc", 32'({flag_z, flag_c}), 32'b11);

      // 4: JMP E; (E) JR 4 -> 2; LDI 0; JNZ 0 not taken; HALT
      do_reset(64'h8E10B0F0000000C4);
      run(100);
      check("t4_jmp_pc", 32'(pc_log[0]), 32'hE);
      check("t4_jr_wrap", 32'(pc_log[1]), 32'h2);
      check("t4_jnz_pc", 32'(pc_log[3]), 32'h6);
      check("t4_pc", 32'(pc), 32'h8);
      check("t4_zc", 32'({flag_z, flag_c}), 32'b10);

      // 5: test 1 program with three wait cycles per fetch
      wait_n = 3;
      do_reset(64'h1121F00000000000);
      run(200);
      check("t5_acc", 32'(acc), 32'h2);
      check("t5_first_ret", 32'(first_ret), 32'd9);
      check("t5_cycles", 32'(cycles), 32'd27);
      check("t5_retires", 32'(nret), 32'd3);

      // 6: reset during FETCH_ARG of ADD, late ack, then HALT/resume
      do_reset(64'h1521F019F0000000);
      begin
         bit found = 1'b0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (imem.req && imem.addr == 4'h3) begin
               found = 1'b1;
               break;
            end
         end
         check("t6_reach_arg", 32'(found), 32'd1);
      end
      check("t6_acc_pre", 32'(acc), 32'h5);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("t6_rst_req", 32'(imem.req), 32'd0);
      check("t6_rst_pc", 32'(pc), 32'h0);
      check("t6_rst_acc", 32'(acc), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      late_ack = 1'b1;
      @(negedge clk);
      late_ack = 1'b0;
      wait_n = 0;
      check("t6_late_ack_addr", 32'(imem.addr), 32'h0);
      check("t6_late_ack_req", 32'(imem.req), 32'd1);
      run(100);
      check("t6_acc_halt", 32'(acc), 32'h6);
      check("t6_pc_halt", 32'(pc), 32'h6);
      repeat (3) @(negedge clk);
      check("t6_frozen", 32'({halted, imem.req, acc}), 32'({1'b1, 1'b0, 4'h6}));
      resume = 1'b1;
      @(negedge clk);
      resume = 1'b0;
      check("t6_resume", 32'({halted, imem.req, imem.addr}), 32'({1'b0, 1'b1, 4'h6}));
      run(100);
      check("t6_acc_end", 32'(acc), 32'h9);
      check("t6_pc_end", 32'(pc), 32'hA);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
